portb_arbiter: RTL and testbench
================================

# portb_arbiter

Sequencer and arbiter for data-RAM port B. Paces ADC sampling, alternating EMG and ECG. Writes each captured sample into that channel's circular buffer in RAM. Shares the remaining port-B cycles between the VGA EMG and ECG trace readers with round-robin fairness. Sits between `adc_data_capture`, `VGAController` and the `RAM` port B in the top-level wrapper; port A (processor) is untouched.

## Interface
Parameters:
- `ADDR_W`, 12, RAM word-address width
- `DATA_W`, 32, RAM data width
- `IDX_W`, 10, buffer-index width
- `DEPTH`, 640, samples per channel buffer; 2 ≤ DEPTH ≤ 2^IDX_W
- `EMG_BASE`, 12'h400, first RAM word of EMG buffer
- `ECG_BASE`, 12'h800, first RAM word of ECG buffer
- `SAMPLE_INTERVAL`, 125000, clocks between sample ticks; ≥ 2

Ports:
- `clock` in 1: single system clock; all logic on rising edge
- `reset` in 1: synchronous, active-low
- `emg_sample` in DATA_W: live EMG ADC word
- `ecg_sample` in DATA_W: live ECG ADC word
- `vga_emg_req` in 1: EMG read request (level)
- `vga_emg_idx` in IDX_W: EMG buffer index to read
- `vga_ecg_req` in 1: ECG read request (level)
- `vga_ecg_idx` in IDX_W: ECG buffer index to read
- `vga_emg_gnt` out 1: EMG read issued this cycle
- `vga_ecg_gnt` out 1: ECG read issued this cycle
- `vga_emg_valid` out 1: one-cycle pulse, `vga_emg_data` updated
- `vga_emg_data` out DATA_W: last EMG read result; held between pulses
- `vga_ecg_valid` out 1: one-cycle pulse, `vga_ecg_data` updated
- `vga_ecg_data` out DATA_W: last ECG read result; held between pulses
- `ram_we` out 1: port-B write enable
- `ram_addr` out ADDR_W: port-B address
- `ram_din` out DATA_W: port-B write data
- `ram_dout` in DATA_W: port-B read data, 1-cycle synchronous read
- `emg_wr_idx` out IDX_W: next EMG index to be written (scroll origin)
- `ecg_wr_idx` out IDX_W: next ECG index to be written

## Operation
- Sample timer counts 0..SAMPLE_INTERVAL-1, then wraps. The terminal count is a tick.
- On a tick: capture `emg_sample` if `chan_sel`=0, else `ecg_sample`, into a pending-write register. Set `wr_pend`, record the channel, toggle `chan_sel`.
- Arbiter, each cycle, strict priority:
  1. `wr_pend`=1: issue the write. `ram_we`=1, `ram_addr`=base+wr_idx of that channel, `ram_din`=captured word. That channel's wr_idx increments; DEPTH-1 wraps to 0. Clear `wr_pend`. No grant.
  2. Otherwise, if any VGA request is high: grant one requester. When both are high, grant the one not granted last (`last_gnt`); a lone requester is granted regardless. `ram_we`=0, `ram_addr`=base+idx of the granted channel; assert its gnt; update `last_gnt`.
  3. Otherwise idle: `ram_we`=0, `ram_addr` holds its last value.
- Out-of-range index (idx ≥ DEPTH): the request is still granted, but no RAM read is issued (`ram_addr` holds). The result data is 0 and valid still pulses.
- Address arithmetic is ADDR_W-bit unsigned: base + zero-extended idx, truncated to ADDR_W.
- A requester may change idx or drop req the cycle after its gnt. Holding req high yields back-to-back reads whenever no write is pending; with both requesting, reads alternate.
- Reset values (`reset`=0 at an edge): timer 0, `chan_sel` 0 (EMG first), `wr_pend` 0, both wr_idx 0, `last_gnt`=EMG (so ECG wins the first tie). All outputs are 0: gnt, valid, data, `ram_we`, `ram_addr`, `ram_din`.
- Reset mid-operation: a pending write is discarded. In-flight reads produce no valid pulse. The buffers are not cleared.

## Timing
- Tick at edge T: write on `ram_*` during cycle T+1. A write is always serviced exactly one cycle after its tick; no sample is ever dropped, since SAMPLE_INTERVAL ≥ 2.
- Read granted in cycle G: `ram_dout` is valid in G+1 and registered at the end of G+1. `vga_*_valid`=1 and `vga_*_data` are updated in cycle G+2. Latency from gnt to valid is 2 cycles, fixed.
- Worst-case wait from req to gnt: 3 cycles (one write, plus one grant to the other requester).
- Reads are pipelined: up to 2 reads in flight, and results return in grant order.
- `vga_*_gnt` and `ram_*` are registered outputs, decided from the inputs sampled at the previous edge.

## Test plan
- Reset hold: `reset`=0 for 3 cycles with random inputs → all outputs 0, `emg_wr_idx`=`ecg_wr_idx`=0, no `ram_we`.
- Sampling, with SAMPLE_INTERVAL=4, DEPTH=4, `emg_sample`=A, `ecg_sample`=B → writes alternate EMG/ECG every 4 cycles. Addresses are EMG_BASE+0, ECG_BASE+0, EMG_BASE+1, and so on. The 5th EMG write goes to EMG_BASE+0 (wrap), and the wr_idx sequence is 0,1,2,3,0.
- Collision: both VGA reqs held high while a tick occurs → the write cycle has no gnt. Surrounding grants alternate ECG, EMG, ECG…; with no write pending, neither requester waits more than 1 cycle.
- Read latency: preload EMG_BASE+5 = 32'hDEAD_BEEF, `vga_emg_req`=1, idx=5 for one cycle → gnt in cycle G, `vga_emg_valid`=1 with data 32'hDEADBEEF at G+2. Data holds afterward.
- Out-of-range: `vga_ecg_idx`=DEPTH → gnt, `ram_addr` unchanged, valid pulse at G+2 with data 0.
- Mid-op reset: assert `reset`=0 the cycle after a tick and one cycle after a gnt → no `ram_we`, no valid pulse. After release, the first write goes to EMG_BASE+0.

Source files
------------

// File: rtl/portb_arbiter.sv
// Data-RAM port-B sequencer: paces alternating EMG/ECG ADC samples into
// per-channel circular buffers and round-robins the spare cycles between VGA readers.
module portb_arbiter #(
   parameter int unsigned       ADDR_W          = 12,
   parameter int unsigned       DATA_W          = 32,
   parameter int unsigned       IDX_W           = 10,
   parameter int unsigned       DEPTH           = 640,
   parameter logic [ADDR_W-1:0] EMG_BASE        = 12'h400,
   parameter logic [ADDR_W-1:0] ECG_BASE        = 12'h800,
   parameter int unsigned       SAMPLE_INTERVAL = 125000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] emg_sample,
   input  logic [DATA_W-1:0] ecg_sample,
   input  logic              vga_emg_req,
   input  logic [IDX_W-1:0]  vga_emg_idx,
   input  logic              vga_ecg_req,
   input  logic [IDX_W-1:0]  vga_ecg_idx,
   output logic              vga_emg_gnt,
   output logic              vga_ecg_gnt,
   output logic              vga_emg_valid,
   output logic [DATA_W-1:0] vga_emg_data,
   output logic              vga_ecg_valid,
   output logic [DATA_W-1:0] vga_ecg_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [IDX_W-1:0]  emg_wr_idx,
   output logic [IDX_W-1:0]  ecg_wr_idx
);

   localparam int unsigned TMR_W  = $clog2(SAMPLE_INTERVAL);
   localparam logic        CH_EMG = 1'b0;
   localparam logic        CH_ECG = 1'b1;

   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              chan_sel_q, chan_sel_d;
   logic              wr_pend_q, wr_pend_d;
   logic              pend_ch_q, pend_ch_d;
   logic [DATA_W-1:0] pend_data_q, pend_data_d;
   logic [IDX_W-1:0]  emg_wr_idx_q, emg_wr_idx_d;
   logic [IDX_W-1:0]  ecg_wr_idx_q, ecg_wr_idx_d;
   logic              last_gnt_q, last_gnt_d;
   logic              emg_gnt_q, emg_gnt_d;
   logic              ecg_gnt_q, ecg_gnt_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;
   logic              s1_vld_q, s1_vld_d;
   logic              s1_ch_q, s1_ch_d;
   logic              s1_oor_q, s1_oor_d;
   logic              s2_vld_q, s2_ch_q, s2_oor_q;
   logic              emg_valid_q, emg_valid_d;
   logic              ecg_valid_q, ecg_valid_d;
   logic [DATA_W-1:0] emg_data_q, emg_data_d;
   logic [DATA_W-1:0] ecg_data_q, ecg_data_d;
   logic              tick_c, sel_ecg_c, oor_c;
   logic [IDX_W-1:0]  rd_idx_c;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
   endfunction

   function automatic logic [ADDR_W-1:0] buf_addr(input logic ch, input logic [IDX_W-1:0] idx);
      return (ch ? ECG_BASE : EMG_BASE) + ADDR_W'(idx);
   endfunction

   // Sample pacing, write-first arbitration and the two-stage read return pipe
   always_comb begin
      tick_c       = (tmr_q == TMR_W'(SAMPLE_INTERVAL - 1));
      tmr_d        = tick_c ? '0 : tmr_q + TMR_W'(1);
      chan_sel_d   = chan_sel_q;
      wr_pend_d    = wr_pend_q;
      pend_ch_d    = pend_ch_q;
      pend_data_d  = pend_data_q;
      emg_wr_idx_d = emg_wr_idx_q;
      ecg_wr_idx_d = ecg_wr_idx_q;
      last_gnt_d   = last_gnt_q;
      emg_gnt_d    = 1'b0;
      ecg_gnt_d    = 1'b0;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_din_d    = ram_din_q;
      s1_vld_d     = 1'b0;
      s1_ch_d      = s1_ch_q;
      s1_oor_d     = s1_oor_q;
      emg_valid_d  = 1'b0;
      ecg_valid_d  = 1'b0;
      emg_data_d   = emg_data_q;
      ecg_data_d   = ecg_data_q;

      // ECG wins a tie only when EMG was granted last
      sel_ecg_c = vga_ecg_req & (~vga_emg_req | (last_gnt_q == CH_EMG));
      rd_idx_c  = sel_ecg_c ? vga_ecg_idx : vga_emg_idx;
      oor_c     = (32'(rd_idx_c) >= DEPTH);

      if (wr_pend_q) begin
         ram_we_d   = 1'b1;
         ram_addr_d = buf_addr(pend_ch_q, (pend_ch_q == CH_ECG) ? ecg_wr_idx_q : emg_wr_idx_q);
         ram_din_d  = pend_data_q;
         wr_pend_d  = 1'b0;
         if (pend_ch_q == CH_ECG) begin
            ecg_wr_idx_d = idx_inc(ecg_wr_idx_q);
         end else begin
            emg_wr_idx_d = idx_inc(emg_wr_idx_q);
         end
      end else if (vga_emg_req || vga_ecg_req) begin
         emg_gnt_d  = ~sel_ecg_c;
         ecg_gnt_d  = sel_ecg_c;
         last_gnt_d = sel_ecg_c;
         s1_vld_d   = 1'b1;
         s1_ch_d    = sel_ecg_c;
         s1_oor_d   = oor_c;
         if (!oor_c) begin
            ram_addr_d = buf_addr(sel_ecg_c, rd_idx_c);
         end
      end

      if (tick_c) begin
         pend_data_d = (chan_sel_q == CH_ECG) ? ecg_sample : emg_sample;
         pend_ch_d   = chan_sel_q;
         wr_pend_d   = 1'b1;
         chan_sel_d  = ~chan_sel_q;
      end

      // Out-of-range reads never touched the RAM, so they return zero
      if (s2_vld_q) begin
         if (s2_ch_q == CH_ECG) begin
            ecg_valid_d = 1'b1;
            ecg_data_d  = s2_oor_q ? '0 : ram_dout;
         end else begin
            emg_valid_d = 1'b1;
            emg_data_d  = s2_oor_q ? '0 : ram_dout;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         tmr_q        <= '0;
         chan_sel_q   <= CH_EMG;
         wr_pend_q    <= 1'b0;
         pend_ch_q    <= CH_EMG;
         pend_data_q  <= '0;
         emg_wr_idx_q <= '0;
         ecg_wr_idx_q <= '0;
         last_gnt_q   <= CH_EMG;
         emg_gnt_q    <= 1'b0;
         ecg_gnt_q    <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
         s1_vld_q     <= 1'b0;
         s1_ch_q      <= CH_EMG;
         s1_oor_q     <= 1'b0;
         s2_vld_q     <= 1'b0;
         s2_ch_q      <= CH_EMG;
         s2_oor_q     <= 1'b0;
         emg_valid_q  <= 1'b0;
         ecg_valid_q  <= 1'b0;
         emg_data_q   <= '0;
         ecg_data_q   <= '0;
      end else begin
         tmr_q        <= tmr_d;
         chan_sel_q   <= chan_sel_d;
         wr_pend_q    <= wr_pend_d;
         pend_ch_q    <= pend_ch_d;
         pend_data_q  <= pend_data_d;
         emg_wr_idx_q <= emg_wr_idx_d;
         ecg_wr_idx_q <= ecg_wr_idx_d;
         last_gnt_q   <= last_gnt_d;
         emg_gnt_q    <= emg_gnt_d;
         ecg_gnt_q    <= ecg_gnt_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
         s1_vld_q     <= s1_vld_d;
         s1_ch_q      <= s1_ch_d;
         s1_oor_q     <= s1_oor_d;
         s2_vld_q     <= s1_vld_q;
         s2_ch_q      <= s1_ch_q;
         s2_oor_q     <= s1_oor_q;
         emg_valid_q  <= emg_valid_d;
         ecg_valid_q  <= ecg_valid_d;
         emg_data_q   <= emg_data_d;
         ecg_data_q   <= ecg_data_d;
      end
   end

   assign vga_emg_gnt   = emg_gnt_q;
   assign vga_ecg_gnt   = ecg_gnt_q;
   assign vga_emg_valid = emg_valid_q;
   assign vga_ecg_valid = ecg_valid_q;
   assign vga_emg_data  = emg_data_q;
   assign vga_ecg_data  = ecg_data_q;
   assign ram_we        = ram_we_q;
   assign ram_addr      = ram_addr_q;
   assign ram_din       = ram_din_q;
   assign emg_wr_idx    = emg_wr_idx_q;
   assign ecg_wr_idx    = ecg_wr_idx_q;

endmodule

// File: tb/tb_portb_arbiter.sv
// Bench for portb_arbiter: arithmetic reference model of sampling/arbitration,
// a synchronous RAM model, and directed plus randomized stimulus.
module tb_portb_arbiter;

   localparam int          ADDR_W   = 12;
   localparam int          DATA_W   = 32;
   localparam int          IDX_W    = 4;
   localparam int          DEPTH    = 8;
   localparam int          SI       = 4;
   localparam logic [11:0] EMG_BASE = 12'h400;
   localparam logic [11:0] ECG_BASE = 12'h800;

   logic              clock = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] emg_sample, ecg_sample;
   logic              vga_emg_req, vga_ecg_req;
   logic [IDX_W-1:0]  vga_emg_idx, vga_ecg_idx;
   logic              vga_emg_gnt, vga_ecg_gnt;
   logic              vga_emg_valid, vga_ecg_valid;
   logic [DATA_W-1:0] vga_emg_data, vga_ecg_data;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din, ram_dout;
   logic [IDX_W-1:0]  emg_wr_idx, ecg_wr_idx;

   always #5 clock = ~clock;

   portb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH),
      .EMG_BASE(EMG_BASE), .ECG_BASE(ECG_BASE), .SAMPLE_INTERVAL(SI)
   ) dut (
      .clock(clock), .reset(reset),
      .emg_sample(emg_sample), .ecg_sample(ecg_sample),
      .vga_emg_req(vga_emg_req), .vga_emg_idx(vga_emg_idx),
      .vga_ecg_req(vga_ecg_req), .vga_ecg_idx(vga_ecg_idx),
      .vga_emg_gnt(vga_emg_gnt), .vga_ecg_gnt(vga_ecg_gnt),
      .vga_emg_valid(vga_emg_valid), .vga_emg_data(vga_emg_data),
      .vga_ecg_valid(vga_ecg_valid), .vga_ecg_data(vga_ecg_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .emg_wr_idx(emg_wr_idx), .ecg_wr_idx(ecg_wr_idx)
   );

   // Synchronous-read RAM with a side port for preloading contents
   logic [31:0] mem [4096];
   logic        pre_we   = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [31:0] pre_data = '0;
   always @(posedge clock) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   // Reference model state
   typedef struct { int due; logic ch; logic [31:0] data; } rd_t;
   rd_t         rq[$];
   logic [31:0] mmem [4096];
   int          e, edge_cnt;
   logic        last;
   logic [31:0] cap;
   logic        x_emg_gnt, x_ecg_gnt, x_we, x_emg_valid, x_ecg_valid;
   logic [11:0] x_addr;
   logic [31:0] x_din, x_emg_data, x_ecg_data;
   logic [IDX_W-1:0] x_emg_widx, x_ecg_widx;
   int          n_checks = 0;
   int          n_errors = 0;

   // e numbers the edges since reset release; ticks fall on e%SI==SI-1 and the
   // n-th sample is written one edge later, alternating EMG/ECG.
   task automatic model_edge();
      int n, idx, w;
      logic ch;
      logic [11:0] a;
      logic [31:0] d;
      edge_cnt++;
      x_emg_gnt = 0; x_ecg_gnt = 0; x_we = 0; x_emg_valid = 0; x_ecg_valid = 0;
      if (!reset) begin
         e = 0; last = 0; rq.delete();
         x_addr = '0; x_din = '0; x_emg_data = '0; x_ecg_data = '0;
         x_emg_widx = '0; x_ecg_widx = '0;
         return;
      end
      if (rq.size() > 0 && rq[0].due == edge_cnt) begin
         if (rq[0].ch) begin x_ecg_valid = 1; x_ecg_data = rq[0].data; end
         else begin x_emg_valid = 1; x_emg_data = rq[0].data; end
         void'(rq.pop_front());
      end
      if (e >= SI && e % SI == 0) begin
         n  = e / SI - 1;
         ch = (n % 2) == 1;
         a  = (ch ? ECG_BASE : EMG_BASE) + 12'((n / 2) % DEPTH);
         x_we = 1; x_addr = a; x_din = cap; mmem[a] = cap;
      end else if (vga_emg_req || vga_ecg_req) begin
         ch   = (vga_emg_req && vga_ecg_req) ? ~last : vga_ecg_req;
         last = ch;
         if (ch) x_ecg_gnt = 1; else x_emg_gnt = 1;
         idx = ch ? int'(vga_ecg_idx) : int'(vga_emg_idx);
         if (idx < DEPTH) begin
            a = (ch ? ECG_BASE : EMG_BASE) + 12'(idx);
            x_addr = a; d = mmem[a];
         end else begin
            d = '0;
         end
         rq.push_back('{edge_cnt + 2, ch, d});
      end
      if (e % SI == SI - 1) cap = (((e / SI) % 2) == 1) ? ecg_sample : emg_sample;
      w = (e >= SI) ? e / SI : 0;
      x_emg_widx = IDX_W'(((w + 1) / 2) % DEPTH);
      x_ecg_widx = IDX_W'((w / 2) % DEPTH);
      e++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("emg_gnt",   32'(vga_emg_gnt),   32'(x_emg_gnt));
      chk("ecg_gnt",   32'(vga_ecg_gnt),   32'(x_ecg_gnt));
      chk("ram_we",    32'(ram_we),        32'(x_we));
      chk("ram_addr",  32'(ram_addr),      32'(x_addr));
      if (x_we) chk("ram_din", ram_din, x_din);
      chk("emg_valid", 32'(vga_emg_valid), 32'(x_emg_valid));
      chk("ecg_valid", 32'(vga_ecg_valid), 32'(x_ecg_valid));
      chk("emg_data",  vga_emg_data,       x_emg_data);
      chk("ecg_data",  vga_ecg_data,       x_ecg_data);
      chk("emg_widx",  32'(emg_wr_idx),    32'(x_emg_widx));
      chk("ecg_widx",  32'(ecg_wr_idx),    32'(x_ecg_widx));
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive_random();
      emg_sample  = $urandom;
      ecg_sample  = $urandom;
      vga_emg_req = 1'($urandom_range(0, 1));
      vga_ecg_req = 1'($urandom_range(0, 1));
      vga_emg_idx = IDX_W'($urandom_range(0, DEPTH + 1));
      vga_ecg_idx = IDX_W'($urandom_range(0, DEPTH + 1));
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d; mmem[a] = d;
      step();
      pre_we = 1'b0;
   endtask

   initial begin
      e = 0; edge_cnt = 0; last = 0; cap = '0;
      reset = 1'b0;
      emg_sample = '0; ecg_sample = '0;
      vga_emg_req = 0; vga_ecg_req = 0; vga_emg_idx = '0; vga_ecg_idx = '0;

      // Reset hold with random inputs
      for (int i = 0; i < 3; i++) begin
         drive_random();
         step();
      end
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_emg_widx", 32'(emg_wr_idx), 32'd0);
      chk("rst_ecg_widx", 32'(ecg_wr_idx), 32'd0);
      vga_emg_req = 0; vga_ecg_req = 0;
      for (int i = 0; i < DEPTH; i++) begin
         preload(EMG_BASE + 12'(i), $urandom);
         preload(ECG_BASE + 12'(i), $urandom);
      end

      // Sampling with constant words, long enough to wrap both buffers
      reset = 1'b1;
      emg_sample = 32'hAAAA_0001;
      ecg_sample = 32'hBBBB_0002;
      repeat (80) step();

      // Both readers requesting continuously across several ticks
      vga_emg_req = 1; vga_ecg_req = 1;
      for (int i = 0; i < 24; i++) begin
         vga_emg_idx = IDX_W'($urandom_range(0, DEPTH - 1));
         vga_ecg_idx = IDX_W'($urandom_range(0, DEPTH - 1));
         emg_sample  = $urandom;
         ecg_sample  = $urandom;
         step();
      end

      // Randomized traffic, including out-of-range indices
      for (int i = 0; i < 300; i++) begin
         drive_random();
         step();
      end

      // Read latency after a fresh reset
      vga_emg_req = 0; vga_ecg_req = 0;
      reset = 1'b0;
      step();
      preload(EMG_BASE + 12'd5, 32'hDEAD_BEEF);
      preload(ECG_BASE + 12'(DEPTH), 32'h1234_5678);
      reset = 1'b1;
      vga_emg_req = 1; vga_emg_idx = 4'd5;
      step();
      chk("lat_gnt", 32'(vga_emg_gnt), 32'd1);
      vga_emg_req = 0;
      step();
      chk("lat_early_valid", 32'(vga_emg_valid), 32'd0);
      step();
      chk("lat_valid", 32'(vga_emg_valid), 32'd1);
      chk("lat_data", vga_emg_data, 32'hDEAD_BEEF);
      step();
      chk("lat_hold_valid", 32'(vga_emg_valid), 32'd0);
      chk("lat_hold_data", vga_emg_data, 32'hDEAD_BEEF);

      // Out-of-range ECG read requested on a write edge
      vga_ecg_req = 1; vga_ecg_idx = IDX_W'(DEPTH);
      step();
      chk("oor_write_wins", 32'(ram_we), 32'd1);
      chk("oor_no_gnt", 32'(vga_ecg_gnt), 32'd0);
      step();
      chk("oor_gnt", 32'(vga_ecg_gnt), 32'd1);
      chk("oor_addr_hold", 32'(ram_addr), 32'(EMG_BASE));
      vga_ecg_req = 0;
      step();
      step();
      chk("oor_valid", 32'(vga_ecg_valid), 32'd1);
      chk("oor_data", vga_ecg_data, 32'd0);

      // Reset the cycle after a tick that coincided with a grant
      for (int k = 0; k < 8 && (e % SI != SI - 1); k++) step();
      vga_emg_req = 1; vga_emg_idx = 4'd2;
      step();
      chk("mid_gnt", 32'(vga_emg_gnt), 32'd1);
      vga_emg_req = 0;
      reset = 1'b0;
      step();
      chk("mid_no_we", 32'(ram_we), 32'd0);
      reset = 1'b1;
      step();
      chk("mid_no_valid_a", 32'(vga_emg_valid), 32'd0);
      step();
      chk("mid_no_valid_b", 32'(vga_emg_valid), 32'd0);
      for (int k = 0; k < 12; k++) begin
         step();
         if (ram_we) break;
      end
      chk("mid_first_we", 32'(ram_we), 32'd1);
      chk("mid_first_addr", 32'(ram_addr), 32'(EMG_BASE));

      for (int i = 0; i < 40; i++) begin
         drive_random();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
